// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle controller: FSM states, datapath selects,
// instruction classes and RV32 opcode constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_OR  = 3'd2,
    ALU_SLT = 3'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JAL    = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_ALU_R  = 3'd1,
    CLS_ALU_I  = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JAL    = 3'd6,
    CLS_LUI    = 3'd7
  } instr_cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: maps the IR to an instruction class,
// the ALU operation for ALU-type instructions, and a legal flag.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  cls,
  output logic [2:0]  alu_op,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register specifiers and immediates are datapath business, not control.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    cls    = CLS_NONE;
    alu_op = ALU_ADD;
    case (opcode)
      OP_R: begin
        case (funct3)
          F3_ADD: begin
            if (funct7 == F7_BASE) begin
              cls    = CLS_ALU_R;
              alu_op = ALU_ADD;
            end else if (funct7 == F7_SUB) begin
              cls    = CLS_ALU_R;
              alu_op = ALU_SUB;
            end
          end
          F3_OR: begin
            if (funct7 == F7_BASE) begin
              cls    = CLS_ALU_R;
              alu_op = ALU_OR;
            end
          end
          F3_SLT: begin
            if (funct7 == F7_BASE) begin
              cls    = CLS_ALU_R;
              alu_op = ALU_SLT;
            end
          end
          default: ;
        endcase
      end
      OP_I: begin
        case (funct3)
          F3_ADD: begin
            cls    = CLS_ALU_I;
            alu_op = ALU_ADD;
          end
          F3_OR: begin
            cls    = CLS_ALU_I;
            alu_op = ALU_OR;
          end
          F3_SLT: begin
            cls    = CLS_ALU_I;
            alu_op = ALU_SLT;
          end
          default: ;
        endcase
      end
      OP_LOAD:   if (funct3 == F3_W) cls = CLS_LOAD;
      OP_STORE:  if (funct3 == F3_W) cls = CLS_STORE;
      OP_BRANCH: begin
        if (funct3 == F3_BEQ) begin
          cls    = CLS_BRANCH;
          alu_op = ALU_SUB;
        end
      end
      OP_JAL: cls = CLS_JAL;
      OP_LUI: cls = CLS_LUI;
      default: ;
    endcase
  end

  assign legal = (cls != CLS_NONE);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset controller: FSM sequencing FETCH/DECODE/EXEC/MEM/WB,
// combinational control decode, retired-instruction counter and sticky trap.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_src_b,
  output logic [2:0]       alu_op,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  state_t     state;
  logic [2:0] dec_cls;
  logic [2:0] dec_op;
  logic       dec_legal;

  ctrl_decode u_decode (
    .instr  (instr),
    .cls    (dec_cls),
    .alu_op (dec_op),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH:  if (mem_ready) state <= ST_DECODE;
        ST_DECODE: state <= dec_legal ? ST_EXEC : ST_TRAP;
        ST_EXEC: begin
          case (dec_cls)
            CLS_ALU_R, CLS_ALU_I:         state <= ST_WB;
            CLS_LOAD, CLS_STORE:          state <= ST_MEM;
            CLS_BRANCH, CLS_JAL, CLS_LUI: state <= ST_FETCH;
            default:                      state <= ST_TRAP;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) state <= (dec_cls == CLS_STORE) ? ST_FETCH : ST_WB;
        end
        ST_WB:   state <= ST_FETCH;
        ST_TRAP: state <= ST_TRAP;
        default: state <= ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Outputs are qualified by rst_n so a request in flight drops the moment reset asserts.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_PLUS4;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    retire    = 1'b0;
    illegal   = 1'b0;
    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        ST_EXEC: begin
          case (dec_cls)
            CLS_ALU_R: begin
              alu_op = dec_op;
            end
            CLS_ALU_I: begin
              alu_op    = dec_op;
              alu_src_b = 1'b1;
            end
            CLS_LOAD, CLS_STORE: begin
              alu_op    = ALU_ADD;
              alu_src_b = 1'b1;
            end
            CLS_BRANCH: begin
              alu_op = ALU_SUB;
              pc_we  = 1'b1;
              pc_src = zero ? PC_BRANCH : PC_PLUS4;
              retire = 1'b1;
            end
            CLS_JAL: begin
              rf_we  = 1'b1;
              wb_sel = WB_PC4;
              pc_we  = 1'b1;
              pc_src = PC_JAL;
              retire = 1'b1;
            end
            CLS_LUI: begin
              rf_we  = 1'b1;
              wb_sel = WB_IMM;
              pc_we  = 1'b1;
              retire = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_req   = 1'b1;
          iord      = 1'b1;
          alu_op    = ALU_ADD;
          alu_src_b = 1'b1;
          mem_we    = (dec_cls == CLS_STORE);
          if (mem_ready && dec_cls == CLS_STORE) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end
        ST_WB: begin
          rf_we  = 1'b1;
          wb_sel = (dec_cls == CLS_LOAD) ? WB_MEM : WB_ALU;
          pc_we  = 1'b1;
          retire = 1'b1;
        end
        ST_TRAP: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control vectors for each
// instruction class, wait states, reset mid-access, trap and counter wrap.
module tb_multicycle_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;

  logic        mem_req, mem_we, iord, ir_we, pc_we, alu_src_b, rf_we, retire, illegal;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  alu_op;
  logic [31:0] instret;

  logic        mem_req_4, mem_we_4, iord_4, ir_we_4, pc_we_4, alu_src_b_4, rf_we_4, retire_4, illegal_4;
  logic [1:0]  pc_src_4, wb_sel_4;
  logic [2:0]  alu_op_4;
  logic [3:0]  instret_4;

  logic [15:0] outs;
  int          checks;
  int          errors;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op), .rf_we(rf_we),
    .wb_sel(wb_sel), .retire(retire), .instret(instret), .illegal(illegal)
  );

  multicycle_ctrl #(.CNT_W(4)) dut_4 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_4), .mem_we(mem_we_4), .iord(iord_4), .ir_we(ir_we_4), .pc_we(pc_we_4),
    .pc_src(pc_src_4), .alu_src_b(alu_src_b_4), .alu_op(alu_op_4), .rf_we(rf_we_4),
    .wb_sel(wb_sel_4), .retire(retire_4), .instret(instret_4), .illegal(illegal_4)
  );

  assign outs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_b,
                 alu_op, rf_we, wb_sel, retire, illegal};

  function automatic logic [15:0] ctl(input logic mr, input logic mw, input logic io,
                                      input logic irw, input logic pcw, input logic [1:0] ps,
                                      input logic asb, input logic [2:0] op, input logic rfw,
                                      input logic [1:0] wb, input logic ret, input logic ill);
    return {mr, mw, io, irw, pcw, ps, asb, op, rfw, wb, ret, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  logic [15:0] v_fetch, v_trap, v_lsmem;

  initial begin
    checks = 0;
    errors = 0;
    v_fetch = ctl(1, 0, 0, 1, 0, PC_PLUS4, 0, ALU_ADD, 0, WB_ALU, 0, 0);
    v_trap  = ctl(0, 0, 0, 0, 0, PC_PLUS4, 0, ALU_ADD, 0, WB_ALU, 0, 1);
    v_lsmem = ctl(1, 0, 1, 0, 0, PC_PLUS4, 1, ALU_ADD, 0, WB_ALU, 0, 0);

    rst_n = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_outs", 32'(outs), 32'h0);
    check("rst_instret", instret, 32'd0);

    // ADDI x1,x0,5
    instr = 32'h00500093; rst_n = 1'b1;
    #1 check("addi_fetch", 32'(outs), 32'(v_fetch));
    nxt(); check("addi_decode", 32'(outs), 32'h0);
    nxt(); check("addi_exec", 32'(outs), 32'(ctl(0,0,0,0,0,PC_PLUS4,1,ALU_ADD,0,WB_ALU,0,0)));
    nxt(); check("addi_wb", 32'(outs), 32'(ctl(0,0,0,0,1,PC_PLUS4,0,ALU_ADD,1,WB_ALU,1,0)));
    nxt(); check("addi_instret", instret, 32'd1);

    // LW with three wait cycles in MEM
    instr = 32'h00402103;
    #1 check("lw_fetch", 32'(outs), 32'(v_fetch));
    nxt(); check("lw_decode", 32'(outs), 32'h0);
    nxt(); check("lw_exec", 32'(outs), 32'(ctl(0,0,0,0,0,PC_PLUS4,1,ALU_ADD,0,WB_ALU,0,0)));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt(); check("lw_mem_wait", 32'(outs), 32'(v_lsmem));
    end
    mem_ready = 1'b1;
    #1 check("lw_mem_ready", 32'(outs), 32'(v_lsmem));
    nxt(); check("lw_wb", 32'(outs), 32'(ctl(0,0,0,0,1,PC_PLUS4,0,ALU_ADD,1,WB_MEM,1,0)));
    nxt(); check("lw_instret", instret, 32'd2);

    // BEQ taken then not taken
    instr = 32'h00000463; zero = 1'b1;
    nxt(); nxt();
    check("beq_taken_exec", 32'(outs), 32'(ctl(0,0,0,0,1,PC_BRANCH,0,ALU_SUB,0,WB_ALU,1,0)));
    zero = 1'b0;
    nxt(); check("beq_instret", instret, 32'd3);
    nxt(); nxt();
    check("beq_not_taken_exec", 32'(outs), 32'(ctl(0,0,0,0,1,PC_PLUS4,0,ALU_SUB,0,WB_ALU,1,0)));
    nxt();

    // SUB x3,x1,x2 and OR x3,x1,x2
    instr = 32'h402081B3;
    nxt(); nxt();
    check("sub_exec", 32'(outs), 32'(ctl(0,0,0,0,0,PC_PLUS4,0,ALU_SUB,0,WB_ALU,0,0)));
    nxt(); check("sub_wb", 32'(outs), 32'(ctl(0,0,0,0,1,PC_PLUS4,0,ALU_ADD,1,WB_ALU,1,0)));
    nxt();
    instr = 32'h0020E1B3;
    nxt(); nxt();
    check("or_exec", 32'(outs), 32'(ctl(0,0,0,0,0,PC_PLUS4,0,ALU_OR,0,WB_ALU,0,0)));
    nxt(); nxt(); check("or_instret", instret, 32'd6);

    // JAL x1,8
    instr = 32'h008000EF;
    nxt(); nxt();
    check("jal_exec", 32'(outs), 32'(ctl(0,0,0,0,1,PC_JAL,0,ALU_ADD,1,WB_PC4,1,0)));
    nxt(); check("jal_instret", instret, 32'd7);

    // SW completing immediately
    instr = 32'h00112023;
    nxt(); nxt();
    check("sw_exec", 32'(outs), 32'(ctl(0,0,0,0,0,PC_PLUS4,1,ALU_ADD,0,WB_ALU,0,0)));
    nxt(); check("sw_mem_ready", 32'(outs), 32'(ctl(1,1,1,0,1,PC_PLUS4,1,ALU_ADD,0,WB_ALU,1,0)));
    nxt(); check("sw_instret", instret, 32'd8);
    check("sw_back_fetch", 32'(outs), 32'(v_fetch));

    // SW interrupted by reset while waiting in MEM
    nxt(); nxt();
    mem_ready = 1'b0;
    nxt(); check("swr_mem_wait", 32'(outs), 32'(ctl(1,1,1,0,0,PC_PLUS4,1,ALU_ADD,0,WB_ALU,0,0)));
    rst_n = 1'b0;
    #1 check("swr_reset_outs", 32'(outs), 32'h0);
    check("swr_reset_instret", instret, 32'd0);
    mem_ready = 1'b1;
    nxt(); check("swr_reset_hold", 32'(outs), 32'h0);

    // 17 LUIs: 4-bit counter wraps 15 -> 0 -> 1
    instr = 32'h000010B7; rst_n = 1'b1;
    #1 check("lui_restart_fetch", 32'(outs), 32'(v_fetch));
    for (int k = 1; k <= 17; k++) begin
      nxt(); nxt();
      check("lui_exec", 32'(outs), 32'(ctl(0,0,0,0,1,PC_PLUS4,0,ALU_ADD,1,WB_IMM,1,0)));
      nxt();
      check("lui_instret4", 32'(instret_4), 32'(k % 16));
      check("lui_instret32", instret, 32'(k));
    end

    // All-ones instruction traps and stays trapped
    instr = 32'hFFFFFFFF;
    nxt(); check("trap_decode", 32'(outs), 32'h0);
    for (int c = 0; c < 20; c++) begin
      nxt(); check("trap_hold", 32'(outs), 32'(v_trap));
    end
    check("trap_instret", instret, 32'd17);
    rst_n = 1'b0;
    #1 check("trap_reset_clears", 32'(outs), 32'h0);

    // R-type with nonzero funct7 (MUL encoding) is illegal
    nxt();
    instr = 32'h022081B3; rst_n = 1'b1;
    nxt(); nxt();
    check("mul_trap", 32'(outs), 32'(v_trap));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
